// File: rtl/sb_tx_pkg.sv
// Shared types and defaults for the sideband TX serializer.
// Imported by the interface, the top and the bench.
package sb_tx_pkg;

  localparam int SB_PKT_BITS = 64;
  localparam int SB_GAP_UI   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } sb_ser_state_e;

endpackage

// File: rtl/sb_tx_serializer_if.sv
// Packet handshake between the TX FIFO and the serializer.
// The FIFO is the master; the serializer is the slave.
interface sb_tx_serializer_if
  import sb_tx_pkg::*;
#(
  parameter int PKT_BITS = SB_PKT_BITS
);

  logic [PKT_BITS-1:0] i_data;
  logic                i_valid;
  logic                o_ready;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready
  );

endinterface

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: LSB-first shift-out of one packet,
// then a fixed low gap before the next packet may start.
module sb_tx_serializer
  import sb_tx_pkg::*;
#(
  parameter int PKT_BITS = SB_PKT_BITS,
  parameter int GAP_UI   = SB_GAP_UI
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sb_tx_serializer_if.slave   pkt_if,
  output logic                TXDATASB,
  output logic                o_clk_en,
  output logic                o_ser_done,
  output logic                o_busy
);

  localparam int BW = $clog2(PKT_BITS) + 1;
  localparam int GW = $clog2(GAP_UI) + 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(PKT_BITS);
  localparam logic [BW-1:0] BIT_PEN  = BW'(PKT_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_UI);

  sb_ser_state_e state_q;
  sb_ser_state_e state_d;

  logic [PKT_BITS-1:0] shreg_q;
  logic [PKT_BITS-1:0] shreg_d;
  logic [BW-1:0]       bit_cnt_q;
  logic [BW-1:0]       bit_cnt_d;
  logic [GW-1:0]       gap_cnt_q;
  logic [GW-1:0]       gap_cnt_d;

  logic tx_d;
  logic clk_en_d;
  logic done_d;
  logic accept;

  // Ready in IDLE, or on the final gap cycle for back-to-back.
  assign pkt_if.o_ready =
    (state_q == IDLE) ||
    ((state_q == GAP) && (gap_cnt_q == GAP_LAST));

  assign accept = pkt_if.i_valid && pkt_if.o_ready;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_q == BIT_LAST) state_d = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = accept ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the shifter, counters and registered outputs.
  always_comb begin
    tx_d      = TXDATASB;
    clk_en_d  = o_clk_en;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (accept) begin
      tx_d      = pkt_if.i_data[0];
      shreg_d   = pkt_if.i_data >> 1;
      bit_cnt_d = BW'(1);
      gap_cnt_d = '0;
      clk_en_d  = 1'b1;
    end else begin
      unique case (state_q)
        SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
            tx_d      = 1'b0;
            clk_en_d  = 1'b0;
            bit_cnt_d = '0;
            gap_cnt_d = GW'(1);
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            done_d    = (bit_cnt_q == BIT_PEN);
          end
        end
        GAP: begin
          tx_d     = 1'b0;
          clk_en_d = 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        default: begin
          tx_d     = 1'b0;
          clk_en_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      TXDATASB   <= 1'b0;
      o_clk_en   <= 1'b0;
      o_ser_done <= 1'b0;
      o_busy     <= 1'b0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      TXDATASB   <= tx_d;
      o_clk_en   <= clk_en_d;
      o_ser_done <= done_d;
      o_busy     <= (state_d != IDLE);
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Randomized self-checking bench for sb_tx_serializer.
// Reference is a timeline model: cycles since last acceptance.
module tb_sb_tx_serializer;
  import sb_tx_pkg::*;

  localparam int P = SB_PKT_BITS;
  localparam int G = SB_GAP_UI;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, clk_en, done, busy;

  always #5 clk = ~clk;

  sb_tx_serializer_if #(.PKT_BITS(P)) bus ();

  sb_tx_serializer #(
    .PKT_BITS(P),
    .GAP_UI  (G)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .pkt_if    (bus.slave),
    .TXDATASB  (txd),
    .o_clk_en  (clk_en),
    .o_ser_done(done),
    .o_busy    (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  // t = edges since the last acceptance; > P+G means idle
  int          t = P + G + 1;
  logic [P-1:0] mpkt = '0;

  function automatic logic [P-1:0] rnd_pkt();
    return P'({$urandom, $urandom});
  endfunction

  function automatic logic [4:0] exp_vec();
    logic tx, ce, dn, bs, rd;
    tx = (t >= 1 && t <= P) ? mpkt[t-1] : 1'b0;
    ce = (t >= 1 && t <= P);
    dn = (t == P);
    bs = (t >= 1 && t <= P + G);
    rd = (t >= P + G);
    return {tx, ce, dn, bs, rd};
  endfunction

  function automatic logic [4:0] act_vec();
    return {txd, clk_en, done, busy, bus.o_ready};
  endfunction

  task automatic cyc(input logic v, input logic [P-1:0] d);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    if (v && t >= P + G) begin
      t = 1;
      mpkt = d;
    end else if (t <= P + G) begin
      t++;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0;
    bus.i_data  = rnd_pkt();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({txd, clk_en, done, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_regs: got %b want 0000",
               {txd, clk_en, done, busy});
    end
    rst_n = 1'b1;
    t = P + G + 1;
    #1;
    vectors++;
    if (act_vec() !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_release: got %b want 00001", act_vec());
    end
  endtask

  task automatic test_single();
    int ce_cnt = 0;
    int done_at = -1;
    cyc(1'b1, P'(1));
    for (int k = 1; k <= P + G + 4; k++) begin
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL single k=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
      if (clk_en) ce_cnt++;
      if (done && done_at < 0) done_at = k;
      cyc(1'b0, rnd_pkt());
    end
    vectors++;
    if (ce_cnt !== P) begin
      miscompares++;
      $display("FAIL single_clk_en_len: got %0d want %0d", ce_cnt, P);
    end
    vectors++;
    if (done_at !== P) begin
      miscompares++;
      $display("FAIL single_done_at: got %0d want %0d", done_at, P);
    end
  endtask

  task automatic test_pattern();
    logic [P-1:0] word = '0;
    logic [P-1:0] want = 64'hA5A5_5A5A_DEAD_BEEF;
    int nb = 0;
    cyc(1'b1, want);
    for (int k = 1; k <= P + G + 2; k++) begin
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL pattern k=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
      if (clk_en && nb < P) begin
        word[nb] = txd;
        nb++;
      end
      cyc(1'b0, rnd_pkt());
    end
    vectors++;
    if (word !== want || nb !== P) begin
      miscompares++;
      $display("FAIL pattern_word: got %h (%0d bits) want %h",
               word, nb, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [P-1:0] p0 = rnd_pkt();
    logic [P-1:0] p1 = rnd_pkt();
    int acc = 0;
    int starts[2];
    int dones[2];
    int ns = 0;
    int nd = 0;
    int lowrun = 0;
    int gap_seen = -1;
    logic prev_ce = 1'b0;
    for (int k = 0; k < 3 * (P + G); k++) begin
      logic go;
      go = (acc < 2);
      if (go && bus.o_ready) acc++;
      cyc(go, (acc == 0 || (acc == 1 && !bus.o_ready)) ? p0 : p1);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
      if (clk_en && !prev_ce && ns < 2) begin
        if (ns == 1) gap_seen = lowrun;
        starts[ns] = k;
        ns++;
      end
      if (done && nd < 2) begin
        dones[nd] = k;
        nd++;
      end
      lowrun = (!clk_en && !txd) ? lowrun + 1 : 0;
      prev_ce = clk_en;
    end
    vectors++;
    if (ns !== 2 || starts[1] - starts[0] !== P + G) begin
      miscompares++;
      $display("FAIL b2b_period: got n=%0d d=%0d want %0d",
               ns, starts[1] - starts[0], P + G);
    end
    vectors++;
    if (nd !== 2 || dones[1] - dones[0] !== P + G) begin
      miscompares++;
      $display("FAIL b2b_done: got n=%0d d=%0d want %0d",
               nd, dones[1] - dones[0], P + G);
    end
    vectors++;
    if (gap_seen !== G) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d want %0d", gap_seen, G);
    end
  endtask

  task automatic test_early_valid();
    int extra_ce = 0;
    cyc(1'b1, rnd_pkt());
    for (int k = 1; k <= P + G + 3; k++) begin
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL early k=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
      if (k > P && clk_en) extra_ce++;
      if (k == P + G + 1) begin
        vectors++;
        if ({busy, bus.o_ready} !== 2'b01) begin
          miscompares++;
          $display("FAIL early_idle: got busy/ready %b want 01",
                   {busy, bus.o_ready});
        end
      end
      cyc((k >= 10 && k < P + 10), rnd_pkt());
    end
    vectors++;
    if (extra_ce !== 0) begin
      miscompares++;
      $display("FAIL early_accept: got %0d clk_en cycles want 0",
               extra_ce);
    end
  endtask

  task automatic test_reset_mid();
    logic [P-1:0] want = rnd_pkt();
    logic [P-1:0] word = '0;
    int nb = 0;
    cyc(1'b1, rnd_pkt());
    for (int k = 1; k < 21; k++) cyc(1'b0, rnd_pkt());
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({txd, clk_en, done, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_regs: got %b want 0000",
               {txd, clk_en, done, busy});
    end
    t = P + G + 1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.o_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_ready: got %b want 1", bus.o_ready);
    end
    @(negedge clk);
    cyc(1'b1, want);
    for (int k = 1; k <= P + G + 2; k++) begin
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL midreset_pkt k=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
      if (clk_en && nb < P) begin
        word[nb] = txd;
        nb++;
      end
      cyc(1'b0, rnd_pkt());
    end
    vectors++;
    if (word !== want) begin
      miscompares++;
      $display("FAIL midreset_word: got %h want %h", word, want);
    end
  endtask

  task automatic test_random();
    logic [P-1:0] pend = rnd_pkt();
    for (int k = 0; k < 2500; k++) begin
      logic v;
      v = ($urandom_range(0, 2) != 0);
      cyc(v, v ? pend : rnd_pkt());
      if (t == 1) pend = rnd_pkt();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc=%0d: got %b want %b",
                 k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < P + G + 2; k++) cyc(1'b0, rnd_pkt());
    for (int k = 0; k < 200; k++) begin
      cyc(1'b0, rnd_pkt());
      vectors++;
      if (act_vec() !== 5'b00001) begin
        miscompares++;
        $display("FAIL stall k=%0d: got %b want 00001",
                 k, act_vec());
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_pattern();
    test_back_to_back();
    test_stall();
    test_early_valid();
    test_reset_mid();
    test_random();
    test_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
